// File: rtl/bell_scheduler_pkg.sv
// Shared types and constants for the bell scheduler: FSM states, melody ROM
// entry layout and melody indices.
package bell_scheduler_pkg;

  typedef enum logic [1:0] {
    IDLE,
    NOTE,
    GAP,
    BEEP
  } state_t;

  localparam int ENTRY_W  = 7;
  localparam int CODE_W   = 3;
  localparam int DUR_W    = 4;
  localparam int DUR_LSB  = 0;
  localparam int CODE_LSB = 4;

  localparam logic [DUR_W-1:0] END_DUR = 4'd0;

  localparam logic [1:0] MEL_OK     = 2'd0;
  localparam logic [1:0] MEL_REFUND = 2'd1;
  localparam logic [1:0] MEL_ALARM  = 2'd2;
  localparam logic [1:0] MEL_SCALE  = 2'd3;

  function automatic logic [ENTRY_W-1:0] mk_entry(input logic [CODE_W-1:0] code,
                                                  input logic [DUR_W-1:0] dur);
    return {code, dur};
  endfunction

  function automatic logic [CODE_W-1:0] entry_code(input logic [ENTRY_W-1:0] e);
    return e[CODE_LSB +: CODE_W];
  endfunction

  function automatic logic [DUR_W-1:0] entry_dur(input logic [ENTRY_W-1:0] e);
    return e[DUR_LSB +: DUR_W];
  endfunction

endpackage

// File: rtl/bell_melody_rom.sv
// Combinational melody ROM: four chimes of eight {code, dur} entries each;
// unused slots hold the end marker.
module bell_melody_rom
  import bell_scheduler_pkg::*;
(
  input  logic [1:0]         sel,
  input  logic [2:0]         index,
  output logic [ENTRY_W-1:0] entry
);

  always_comb begin
    entry = mk_entry(3'd0, END_DUR);
    case (sel)
      MEL_OK: begin
        case (index)
          3'd0:    entry = mk_entry(3'd1, 4'd4);
          3'd1:    entry = mk_entry(3'd3, 4'd4);
          3'd2:    entry = mk_entry(3'd5, 4'd4);
          default: entry = mk_entry(3'd0, END_DUR);
        endcase
      end
      MEL_REFUND: begin
        case (index)
          3'd0:    entry = mk_entry(3'd5, 4'd4);
          3'd1:    entry = mk_entry(3'd3, 4'd4);
          3'd2:    entry = mk_entry(3'd1, 4'd4);
          default: entry = mk_entry(3'd0, END_DUR);
        endcase
      end
      MEL_ALARM: begin
        case (index)
          3'd0:    entry = mk_entry(3'd1, 4'd2);
          3'd1:    entry = mk_entry(3'd1, 4'd2);
          3'd2:    entry = mk_entry(3'd1, 4'd8);
          default: entry = mk_entry(3'd0, END_DUR);
        endcase
      end
      MEL_SCALE: begin
        case (index)
          3'd0:    entry = mk_entry(3'd7, 4'd2);
          3'd1:    entry = mk_entry(3'd6, 4'd2);
          3'd2:    entry = mk_entry(3'd5, 4'd2);
          3'd3:    entry = mk_entry(3'd4, 4'd2);
          3'd4:    entry = mk_entry(3'd3, 4'd2);
          3'd5:    entry = mk_entry(3'd2, 4'd2);
          3'd6:    entry = mk_entry(3'd1, 4'd2);
          default: entry = mk_entry(3'd1, 4'd2);
        endcase
      end
      default: entry = mk_entry(3'd0, END_DUR);
    endcase
  end

endmodule

// File: rtl/bell_scheduler.sv
// Bell sequencer: arbitrates key beeps and ROM melodies onto one bell and
// times each note, inter-note gap and beep in units of TICK_DIV clocks.
module bell_scheduler
  import bell_scheduler_pkg::*;
#(
  parameter int TICK_DIV   = 500000,
  parameter int GAP_TICKS  = 2,
  parameter int BEEP_CODE  = 6,
  parameter int BEEP_TICKS = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       play_req,
  input  logic [1:0] melody_sel,
  input  logic       beep_req,
  input  logic       stop,
  output logic [2:0] bell_code,
  output logic       busy,
  output logic       done
);

  localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  state_t               state, state_n;
  logic [TICK_W-1:0]    tick_cnt, tick_n;
  logic [DUR_W-1:0]     dur_cnt, dur_n, note_dur, note_dur_n, lim;
  logic [2:0]           idx, idx_n, code_n, rom_idx;
  logic [1:0]           sel_q, sel_n, rom_sel;
  logic                 busy_n, done_n, last_tick, expired;
  logic [ENTRY_W-1:0]   rom_entry;

  // One ROM port: entry 0 of the requested melody when a start is possible,
  // the following entry while in GAP so the next note is known at gap end.
  assign rom_sel = (state == IDLE || state == BEEP) ? melody_sel : sel_q;
  assign rom_idx = (state == GAP) ? idx + 3'd1 : 3'd0;

  bell_melody_rom u_rom (
    .sel   (rom_sel),
    .index (rom_idx),
    .entry (rom_entry)
  );

  always_comb begin
    lim = '0;
    case (state)
      NOTE:    lim = note_dur;
      GAP:     lim = DUR_W'(GAP_TICKS);
      BEEP:    lim = DUR_W'(BEEP_TICKS);
      default: lim = '0;
    endcase
  end

  assign last_tick = (tick_cnt == TICK_W'(TICK_DIV - 1));
  assign expired   = last_tick && (dur_cnt == lim - 4'd1);

  always_comb begin
    state_n    = state;
    code_n     = bell_code;
    busy_n     = busy;
    done_n     = 1'b0;
    idx_n      = idx;
    sel_n      = sel_q;
    note_dur_n = note_dur;
    tick_n     = tick_cnt;
    dur_n      = dur_cnt;

    if (stop) begin
      if (state != IDLE) begin
        state_n = IDLE;
        code_n  = '0;
        busy_n  = 1'b0;
      end
    end else if (play_req && (state == IDLE || state == BEEP)) begin
      sel_n = melody_sel;
      idx_n = '0;
      if (entry_dur(rom_entry) != END_DUR) begin
        state_n    = NOTE;
        code_n     = entry_code(rom_entry);
        note_dur_n = entry_dur(rom_entry);
        busy_n     = 1'b1;
      end else begin
        state_n = IDLE;
        code_n  = '0;
        busy_n  = 1'b0;
        done_n  = 1'b1;
      end
    end else begin
      case (state)
        IDLE: begin
          if (beep_req) begin
            state_n = BEEP;
            code_n  = 3'(BEEP_CODE);
            busy_n  = 1'b1;
          end
        end
        NOTE: begin
          if (expired) begin
            state_n = GAP;
            code_n  = '0;
          end
        end
        GAP: begin
          if (expired) begin
            if (idx == 3'd7 || entry_dur(rom_entry) == END_DUR) begin
              state_n = IDLE;
              busy_n  = 1'b0;
              done_n  = 1'b1;
            end else begin
              state_n    = NOTE;
              idx_n      = idx + 3'd1;
              code_n     = entry_code(rom_entry);
              note_dur_n = entry_dur(rom_entry);
            end
          end
        end
        BEEP: begin
          if (expired) begin
            state_n = IDLE;
            code_n  = '0;
            busy_n  = 1'b0;
            done_n  = 1'b1;
          end
        end
        default: state_n = IDLE;
      endcase
    end

    if (state_n != state || state_n == IDLE) begin
      tick_n = '0;
      dur_n  = '0;
    end else if (last_tick) begin
      tick_n = '0;
      dur_n  = dur_cnt + 4'd1;
    end else begin
      tick_n = tick_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      bell_code <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      idx       <= '0;
      sel_q     <= '0;
      note_dur  <= '0;
      tick_cnt  <= '0;
      dur_cnt   <= '0;
    end else begin
      state     <= state_n;
      bell_code <= code_n;
      busy      <= busy_n;
      done      <= done_n;
      idx       <= idx_n;
      sel_q     <= sel_n;
      note_dur  <= note_dur_n;
      tick_cnt  <= tick_n;
      dur_cnt   <= dur_n;
    end
  end

endmodule

// File: tb/tb_bell_scheduler.sv
// Scoreboard bench for bell_scheduler: stimulus pushes per-cycle expected
// outputs; a negedge monitor pops and compares them against the DUT.
module tb_bell_scheduler;

  localparam int TICK_DIV   = 4;
  localparam int GAP_TICKS  = 1;
  localparam int BEEP_CODE  = 6;
  localparam int BEEP_TICKS = 5;
  localparam int NEVER      = 1000000;

  logic       clk = 1'b0;
  logic       rst, play_req, beep_req, stop;
  logic [1:0] melody_sel;
  logic [2:0] bell_code;
  logic       busy, done;

  typedef struct {
    int         cyc;
    logic [2:0] code;
    logic       busy;
    logic       done;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  // Hand-written melody tables: note codes and durations in ticks, 0 = end.
  int mcode[4][8] = '{'{1, 3, 5, 0, 0, 0, 0, 0},
                      '{5, 3, 1, 0, 0, 0, 0, 0},
                      '{1, 1, 1, 0, 0, 0, 0, 0},
                      '{7, 6, 5, 4, 3, 2, 1, 1}};
  int mdur[4][8]  = '{'{4, 4, 4, 0, 0, 0, 0, 0},
                      '{4, 4, 4, 0, 0, 0, 0, 0},
                      '{2, 2, 8, 0, 0, 0, 0, 0},
                      '{2, 2, 2, 2, 2, 2, 2, 2}};

  bell_scheduler #(
    .TICK_DIV   (TICK_DIV),
    .GAP_TICKS  (GAP_TICKS),
    .BEEP_CODE  (BEEP_CODE),
    .BEEP_TICKS (BEEP_TICKS)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .play_req   (play_req),
    .melody_sel (melody_sel),
    .beep_req   (beep_req),
    .stop       (stop),
    .bell_code  (bell_code),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      checks++;
      if (e.cyc != cyc || bell_code !== e.code || busy !== e.busy || done !== e.done) begin
        errors++;
        $display("FAIL outputs@cycle%0d (now %0d): got code=%0d busy=%0b done=%0b, want code=%0d busy=%0b done=%0b",
                 e.cyc, cyc, bell_code, busy, done, e.code, e.busy, e.done);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) tick();
  endtask

  task automatic push_span(input int start, input int len, input int code,
                           input bit b, input bit d, input int last);
    exp_t x;
    for (int k = 0; k < len; k++) begin
      if (start + k <= last) begin
        x.cyc  = start + k;
        x.code = 3'(code);
        x.busy = b;
        x.done = d;
        q.push_back(x);
      end
    end
  endtask

  // Expected schedule for a melody requested at cycle c0; fin = done cycle.
  task automatic push_melody(input int c0, input int sel, input int last, output int fin);
    int t = c0 + 1;
    for (int i = 0; i < 8; i++) begin
      if (mdur[sel][i] == 0) break;
      push_span(t, mdur[sel][i] * TICK_DIV, mcode[sel][i], 1'b1, 1'b0, last);
      t += mdur[sel][i] * TICK_DIV;
      push_span(t, GAP_TICKS * TICK_DIV, 0, 1'b1, 1'b0, last);
      t += GAP_TICKS * TICK_DIV;
    end
    push_span(t, 1, 0, 1'b0, 1'b1, last);
    fin = t;
  endtask

  initial begin
    int c, fin;
    rst = 1'b1; play_req = 1'b1; beep_req = 1'b0; stop = 1'b0; melody_sel = 2'd0;

    // Reset held two cycles with play_req high
    tick();
    c = cyc;
    push_span(c, 4, 0, 1'b0, 1'b0, NEVER);
    tick();
    rst = 1'b0; play_req = 1'b0;
    wait_until(c + 3);

    // Melody 0
    c = cyc; play_req = 1'b1; melody_sel = 2'd0;
    push_melody(c, 0, NEVER, fin);
    push_span(fin + 1, 3, 0, 1'b0, 1'b0, NEVER);
    tick(); play_req = 1'b0;
    wait_until(fin + 3);

    // Melody 3: all slots, no wrap
    c = cyc; play_req = 1'b1; melody_sel = 2'd3;
    push_melody(c, 3, NEVER, fin);
    push_span(fin + 1, 3, 0, 1'b0, 1'b0, NEVER);
    tick(); play_req = 1'b0;
    wait_until(fin + 3);

    // Play and beep together: melody wins
    c = cyc; play_req = 1'b1; beep_req = 1'b1; melody_sel = 2'd0;
    push_melody(c, 0, NEVER, fin);
    push_span(fin + 1, 3, 0, 1'b0, 1'b0, NEVER);
    tick(); play_req = 1'b0; beep_req = 1'b0;
    wait_until(fin + 3);

    // Beep during melody 1 ignored
    c = cyc; play_req = 1'b1; melody_sel = 2'd1;
    push_melody(c, 1, NEVER, fin);
    push_span(fin + 1, 3, 0, 1'b0, 1'b0, NEVER);
    tick(); play_req = 1'b0;
    wait_until(c + 10);
    beep_req = 1'b1; tick(); beep_req = 1'b0;
    wait_until(fin + 3);

    // Beep alone
    c = cyc; beep_req = 1'b1;
    push_span(c + 1, BEEP_TICKS * TICK_DIV, BEEP_CODE, 1'b1, 1'b0, NEVER);
    push_span(c + 1 + BEEP_TICKS * TICK_DIV, 1, 0, 1'b0, 1'b1, NEVER);
    push_span(c + 2 + BEEP_TICKS * TICK_DIV, 2, 0, 1'b0, 1'b0, NEVER);
    tick(); beep_req = 1'b0;
    wait_until(c + 3 + BEEP_TICKS * TICK_DIV);

    // Beep preempted by play_req 6 cycles later
    c = cyc; beep_req = 1'b1;
    push_span(c + 1, 6, BEEP_CODE, 1'b1, 1'b0, NEVER);
    tick(); beep_req = 1'b0;
    wait_until(c + 6);
    play_req = 1'b1; melody_sel = 2'd0;
    push_melody(c + 6, 0, NEVER, fin);
    push_span(fin + 1, 3, 0, 1'b0, 1'b0, NEVER);
    tick(); play_req = 1'b0;
    wait_until(fin + 3);

    // Stop at cycle 8 of melody 2
    c = cyc; play_req = 1'b1; melody_sel = 2'd2;
    push_melody(c, 2, c + 8, fin);
    push_span(c + 9, 30, 0, 1'b0, 1'b0, NEVER);
    tick(); play_req = 1'b0;
    wait_until(c + 8);
    stop = 1'b1; tick(); stop = 1'b0;
    wait_until(c + 38);

    // Reset at cycle 25 of melody 1, then a clean restart
    c = cyc; play_req = 1'b1; melody_sel = 2'd1;
    push_melody(c, 1, c + 25, fin);
    push_span(c + 26, 5, 0, 1'b0, 1'b0, NEVER);
    tick(); play_req = 1'b0;
    wait_until(c + 25);
    rst = 1'b1; tick(); rst = 1'b0;
    wait_until(c + 30);
    c = cyc; play_req = 1'b1; melody_sel = 2'd1;
    push_melody(c, 1, NEVER, fin);
    push_span(fin + 1, 3, 0, 1'b0, 1'b0, NEVER);
    tick(); play_req = 1'b0;
    wait_until(fin + 3);

    tick(); tick();
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    checks++;
    errors++;
    $display("FAIL watchdog: got cycle %0d, want completion", cyc);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
